crc_rx_sequencer: RTL and testbench
===================================

# crc_rx_sequencer

Packet-level controller for the receive-side CRC-32 check. It accepts a word stream framed as header, payload and trailing CRC word, and sequences the payload through a one-word-per-cycle CRC-32 step unit. It compares the running CRC against the received CRC word and issues one result record per packet on a valid/ready port. It sits between the link deframer and packet-buffer commit logic and replaces ad-hoc per-word CRC control.

## Interface
Parameters:
- MAX_WORDS, 1024: largest legal payload length in words. Header length is compared against this value.
- TIMEOUT, 256: number of idle cycles allowed mid-packet before the packet is aborted. Minimum 2.
- CNT_W, 16: width of the packet statistics counters.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  32  stream word.
- s_valid  in  1  stream word valid.
- s_last  in  1  marks the final word of a packet.
- s_ready  out  1  the controller accepts a word. A beat transfers when s_valid && s_ready.
- res_valid  out  1  a result record is available.
- res_ready  in  1  the consumer takes the record.
- res_tag  out  16  tag field from the packet header.
- res_pass  out  1  1 when the CRC matched and no error occurred.
- res_err  out  3  error code. 0 OK, 1 CRC_BAD, 2 LEN_SHORT, 3 LEN_LONG, 4 ZERO_LEN, 5 TOO_LONG, 6 TIMEOUT.
- pkt_ok_cnt  out  CNT_W  number of passed packets. Saturates at the maximum value.
- pkt_err_cnt  out  CNT_W  number of failed packets. Saturates at the maximum value.

## Operation
- Packet format:
  - Header word: [15:0] is the payload length N; [31:16] is the tag.
  - Then N payload words.
  - Then one CRC word, which must carry s_last.
- CRC algorithm: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Each word is processed LSB first (byte 0 = s_data[7:0]).
  - The final CRC is ~crc_reg. The packet passes when ~crc_reg == CRC word.
- FSM states:
  - IDLE→HDR is implicit. HDR is the reset state.
  - HDR: accept the header and latch the tag. Initialise crc_reg to 0xFFFFFFFF and the remaining count to N.
    - N==0 → ZERO_LEN.
    - N>MAX_WORDS → TOO_LONG.
    - For both errors: go to REPORT if s_last is set, else to DRAIN.
    - s_last on a valid header with N>0 → LEN_SHORT, go to REPORT.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: each beat updates crc_reg and decrements the count.
    - s_last before the count reaches 0 → LEN_SHORT, go to REPORT.
    - After the last payload beat, go to CRCW.
  - CRCW: the next beat is the CRC word.
    - With s_last: compare (CRC_BAD or OK), go to REPORT.
    - Without s_last: LEN_LONG, go to DRAIN.
  - DRAIN: accept and discard words until s_last, then go to REPORT. The error code already recorded is kept.
  - REPORT: res_valid=1. On res_ready, go to HDR.
- Error precedence: the first error detected in the packet is the one reported. A later error never overwrites it.
- Counters: incremented once per record, on the res_valid && res_ready handshake. pkt_ok_cnt increments when res_pass is 1, pkt_err_cnt otherwise.
- Timeout:
  - An idle counter runs in PAYLOAD, CRCW and DRAIN. It clears on every accepted beat.
  - When it reaches TIMEOUT, record TIMEOUT and go to REPORT.
  - Words that arrive afterwards are parsed as a new header.

## Timing
- Reset values: s_ready=0, res_valid=0, res_tag=0, res_pass=0, res_err=0, both counters 0. The FSM is in HDR, crc_reg=0xFFFFFFFF.
- s_ready is a registered 1 in HDR, PAYLOAD, CRCW and DRAIN, and 0 in REPORT.
- s_ready goes to 1 the cycle after reset deasserts.
- Throughput is one word per cycle, with no bubbles inside a packet.
- Latency: the CRC word or terminating beat is accepted in cycle t. res_valid rises in cycle t+1.
- The record is held stable while res_valid && !res_ready.
- After the handshake, s_ready returns to 1 in the next cycle, so there is one bubble per packet.
- Reset asserted mid-packet:
  - Return to HDR next cycle.
  - Discard any pending record.
  - Clear the counters.
- Counter saturation: at the all-ones value a counter holds. It does not wrap.

## Structure
- Package crc_rx_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320
  - CRC32_INIT = 32'hFFFFFFFF
  - the err_e enum (3-bit)
  - the state_e enum
  - the header field offsets
- Sub-module crc32_word_step: combinational. Inputs are crc_in[31:0] and data[31:0]; output is crc_out[31:0]. It performs 32 unrolled bit steps. The controller registers crc_out. This unit is reused by the TX-side generator.

## Test plan
- Header 0x00A5_0001, payload 0x00000000, CRC 0x2144DF1C with s_last → res_pass=1, err=0, tag=0x00A5, res_valid at t+1, pkt_ok_cnt=1.
- Same packet with CRC word 0x2144DF1D → res_pass=0, err=1, pkt_err_cnt=1.
- Header N=3, s_last on the 2nd payload word → err=2 (LEN_SHORT). The next header parses correctly.
- Header N=0 without s_last, then 2 words with the last carrying s_last → err=4 after the drain. Header N=MAX_WORDS+1 → err=5.
- N=2, one payload word, then idle for TIMEOUT cycles → err=6 (TIMEOUT). Also: hold res_ready=0 for 10 cycles → record stable, s_ready=0.
- Back-to-back packets with reset asserted mid-payload → outputs at reset values, no record. After the counter is forced to saturation, it stays at 0xFFFF.

Source files
------------

// File: rtl/crc_rx_pkg.sv
// Shared types and constants for the receive-side CRC-32 packet sequencer
// and the reusable CRC-32 word step.
package crc_rx_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // Header word field offsets
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;
  localparam int HDR_TAG_LSB = 16;
  localparam int HDR_TAG_MSB = 31;

  typedef struct packed {
    logic [HDR_TAG_MSB-HDR_TAG_LSB:0] tag;
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len;
  } hdr_t;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_CRC_BAD   = 3'd1,
    ERR_LEN_SHORT = 3'd2,
    ERR_LEN_LONG  = 3'd3,
    ERR_ZERO_LEN  = 3'd4,
    ERR_TOO_LONG  = 3'd5,
    ERR_TIMEOUT   = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CRCW    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

  // The first error seen in a packet sticks; later ones are ignored.
  function automatic err_e first_err(input err_e cur, input err_e nw);
    return (cur == ERR_OK) ? nw : cur;
  endfunction

endpackage

// File: rtl/crc32_word_step.sv
// One 32-bit word of reflected CRC-32, LSB first, fully unrolled.
// Purely combinational: zero latency, no flow control.
module crc32_word_step
  import crc_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_in;
    for (int i = 0; i < 32; i++) begin
      w_crc = {1'b0, w_crc[31:1]} ^ ((w_crc[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/crc_rx_sequencer.sv
// Receive CRC-32 packet controller: header / payload / CRC word in, one result record out.
// Record valid the cycle after the terminating beat; s_ready drops while a record waits (one bubble per packet).
module crc_rx_sequencer
  import crc_rx_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_tag,
  output logic             res_pass,
  output logic [2:0]       res_err,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_err_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e             r_state;
  logic [31:0]        r_crc;
  logic [15:0]        r_cnt;
  logic [15:0]        r_tag;
  err_e               r_err;
  logic               r_pass;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_s_ready;
  logic [CNT_W-1:0]   r_ok_cnt;
  logic [CNT_W-1:0]   r_err_cnt;

  state_e             w_state_nxt;
  logic [31:0]        w_crc_nxt;
  logic [15:0]        w_cnt_nxt;
  logic [15:0]        w_tag_nxt;
  err_e               w_err_nxt;
  logic               w_pass_nxt;
  logic [IDLE_W-1:0]  w_idle_nxt;
  logic [31:0]        w_crc_step;
  logic               w_acc;
  logic               w_res_hs;
  logic               w_in_pkt;
  hdr_t               w_hdr;

  assign w_acc    = s_valid && r_s_ready;
  assign w_res_hs = (r_state == ST_REPORT) && res_ready;
  assign w_in_pkt = (r_state == ST_PAYLOAD) || (r_state == ST_CRCW) || (r_state == ST_DRAIN);
  assign w_hdr    = hdr_t'(s_data);

  crc32_word_step u_step (
    .crc_in  (r_crc),
    .data    (s_data),
    .crc_out (w_crc_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_tag_nxt   = r_tag;
    w_err_nxt   = r_err;
    w_pass_nxt  = r_pass;
    w_idle_nxt  = r_idle;

    case (r_state)
      ST_HDR: begin
        if (w_acc) begin
          w_tag_nxt  = w_hdr.tag;
          w_crc_nxt  = CRC32_INIT;
          w_cnt_nxt  = w_hdr.len;
          w_err_nxt  = ERR_OK;
          w_pass_nxt = 1'b0;
          w_idle_nxt = '0;
          if (w_hdr.len == 16'd0) begin
            w_err_nxt   = ERR_ZERO_LEN;
            w_state_nxt = s_last ? ST_REPORT : ST_DRAIN;
          end else if (32'(w_hdr.len) > MAX_WORDS) begin
            w_err_nxt   = ERR_TOO_LONG;
            w_state_nxt = s_last ? ST_REPORT : ST_DRAIN;
          end else if (s_last) begin
            w_err_nxt   = ERR_LEN_SHORT;
            w_state_nxt = ST_REPORT;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_acc) begin
          w_crc_nxt = w_crc_step;
          w_cnt_nxt = r_cnt - 16'd1;
          if (s_last) begin
            w_err_nxt   = first_err(r_err, ERR_LEN_SHORT);
            w_state_nxt = ST_REPORT;
          end else if (r_cnt == 16'd1) begin
            w_state_nxt = ST_CRCW;
          end
        end
      end
      ST_CRCW: begin
        if (w_acc) begin
          if (s_last) begin
            w_pass_nxt  = (~r_crc == s_data);
            w_err_nxt   = (~r_crc == s_data) ? ERR_OK : ERR_CRC_BAD;
            w_state_nxt = ST_REPORT;
          end else begin
            w_err_nxt   = first_err(r_err, ERR_LEN_LONG);
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_acc && s_last) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          w_state_nxt = ST_HDR;
        end
      end
      default: begin
        w_state_nxt = ST_HDR;
      end
    endcase

    // Idle watchdog only matters mid-packet; an accepted beat always wins.
    if (w_in_pkt) begin
      if (w_acc) begin
        w_idle_nxt = '0;
      end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
        w_idle_nxt  = '0;
        w_err_nxt   = first_err(r_err, ERR_TIMEOUT);
        w_pass_nxt  = 1'b0;
        w_state_nxt = ST_REPORT;
      end else begin
        w_idle_nxt = r_idle + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_HDR;
      r_crc     <= CRC32_INIT;
      r_cnt     <= '0;
      r_tag     <= '0;
      r_err     <= ERR_OK;
      r_pass    <= 1'b0;
      r_idle    <= '0;
      r_s_ready <= 1'b0;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_crc     <= w_crc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tag     <= w_tag_nxt;
      r_err     <= w_err_nxt;
      r_pass    <= w_pass_nxt;
      r_idle    <= w_idle_nxt;
      r_s_ready <= (w_state_nxt != ST_REPORT);
      if (w_res_hs) begin
        if (r_pass) begin
          if (r_ok_cnt != {CNT_W{1'b1}}) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
        end else begin
          if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign res_valid   = (r_state == ST_REPORT);
  assign res_tag     = r_tag;
  assign res_pass    = r_pass;
  assign res_err     = r_err;
  assign pkt_ok_cnt  = r_ok_cnt;
  assign pkt_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_crc_rx_sequencer.sv
// Randomised packet stream against a packet-level reference (byte-wise CRC-32, outcome per packet kind).
module tb_crc_rx_sequencer;

  localparam int MAXW = 16;
  localparam int TMO  = 8;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          g;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_tag;
  logic          res_pass;
  logic [2:0]    res_err;
  logic [CW-1:0] pkt_ok_cnt;
  logic [CW-1:0] pkt_err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_ok = 0;
  int exp_bad = 0;
  beat_t bq[$];

  crc_rx_sequencer #(.MAX_WORDS(MAXW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_tag    (res_tag),
    .res_pass   (res_pass),
    .res_err    (res_err),
    .pkt_ok_cnt (pkt_ok_cnt),
    .pkt_err_cnt(pkt_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc32_ref(input wq_t q);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int j = 0; j < 4; j++) begin
        b = q[i][8*j +: 8];
        c = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic put(input logic [31:0] d, input logic l, input int g);
    beat_t bt;
    bt.d = d;
    bt.l = l;
    bt.g = g;
    bq.push_back(bt);
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send_beat(input logic [31:0] d, input logic l, input int g);
    int n;
    s_valid = 1'b0;
    repeat (g) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    chk("s_ready_at_beat", 32'(s_ready), 1);
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] tag, input logic [2:0] e, input bit tmo, input int hold);
    int cyc;
    foreach (bq[i]) send_beat(bq[i].d, bq[i].l, bq[i].g);
    if (!tmo) begin
      chk("res_valid_latency", 32'(res_valid), 1);
    end else begin
      cyc = 0;
      while (!res_valid && cyc < TMO + 6) begin
        @(negedge clk);
        cyc++;
      end
      chk("timeout_cycles", 32'(cyc), TMO);
    end
    cyc = 0;
    while (!res_valid && cyc < TMO + 6) begin
      @(negedge clk);
      cyc++;
    end
    chk("res_tag", 32'(res_tag), 32'(tag));
    chk("res_err", 32'(res_err), 32'(e));
    chk("res_pass", 32'(res_pass), 32'(e == 3'd0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid), 1);
      chk("hold_s_ready", 32'(s_ready), 0);
      chk("hold_res_tag", 32'(res_tag), 32'(tag));
      chk("hold_res_err", 32'(res_err), 32'(e));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (e == 3'd0) begin
      if (exp_ok < MAXC) exp_ok++;
    end else begin
      if (exp_bad < MAXC) exp_bad++;
    end
    chk("pkt_ok_cnt", 32'(pkt_ok_cnt), 32'(exp_ok));
    chk("pkt_err_cnt", 32'(pkt_err_cnt), 32'(exp_bad));
    chk("post_res_valid", 32'(res_valid), 0);
    chk("post_s_ready", 32'(s_ready), 1);
  endtask

  // kind: 0 ok, 1 bad crc, 2 short, 3 long, 4 zero len, 5 too long, 6 timeout
  task automatic run_pkt(input int kind, input int n, input int hold);
    wq_t         pl;
    logic [15:0] tag;
    logic [31:0] c;
    logic [31:0] hdr;
    logic [2:0]  e;
    int          k;
    int          m;
    tag = 16'($urandom);
    hdr = {tag, 16'(n)};
    bq.delete();
    for (int i = 0; i < n; i++) pl.push_back($urandom);
    c = crc32_ref(pl);
    e = 3'(kind);
    case (kind)
      0, 1: begin
        put(hdr, 1'b0, 0);
        foreach (pl[i]) put(pl[i], 1'b0, rgap());
        put((kind == 1) ? (c ^ (32'd1 << $urandom_range(0, 31))) : c, 1'b1, rgap());
      end
      2: begin
        k = $urandom_range(0, n);
        put(hdr, k == 0, 0);
        for (int i = 0; i < k; i++) put(pl[i], i == k - 1, rgap());
      end
      3: begin
        put(hdr, 1'b0, 0);
        foreach (pl[i]) put(pl[i], 1'b0, rgap());
        put(c, 1'b0, rgap());
        m = $urandom_range(1, 3);
        for (int j = 0; j < m; j++) put($urandom, j == m - 1, rgap());
      end
      4, 5: begin
        m = $urandom_range(0, 3);
        put(hdr, m == 0, 0);
        for (int j = 0; j < m; j++) put($urandom, j == m - 1, rgap());
      end
      default: begin
        k = $urandom_range(0, n);
        put(hdr, 1'b0, 0);
        for (int i = 0; i < k; i++) put(pl[i], 1'b0, rgap());
      end
    endcase
    xfer(tag, e, kind == 6, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int n;
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_tag", 32'(res_tag), 0);
    chk("rst_res_pass", 32'(res_pass), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_ok_cnt", 32'(pkt_ok_cnt), 0);
    chk("rst_err_cnt", 32'(pkt_err_cnt), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", 32'(s_ready), 1);

    // Known vector: CRC-32 of four zero bytes
    bq.delete();
    put(32'h00A5_0001, 1'b0, 0);
    put(32'h0000_0000, 1'b0, 0);
    put(32'h2144_DF1C, 1'b1, 0);
    xfer(16'h00A5, 3'd0, 1'b0, 2);
    bq.delete();
    put(32'h00A5_0001, 1'b0, 0);
    put(32'h0000_0000, 1'b0, 0);
    put(32'h2144_DF1D, 1'b1, 0);
    xfer(16'h00A5, 3'd1, 1'b0, 0);

    bq.delete();
    put(32'h1234_0003, 1'b0, 0);
    put($urandom, 1'b0, 0);
    put($urandom, 1'b1, 0);
    xfer(16'h1234, 3'd2, 1'b0, 0);
    run_pkt(0, 3, 0);

    bq.delete();
    put(32'h0042_0000, 1'b0, 0);
    put($urandom, 1'b0, 0);
    put($urandom, 1'b1, 0);
    xfer(16'h0042, 3'd4, 1'b0, 1);
    bq.delete();
    put({16'h0077, 16'(MAXW + 1)}, 1'b1, 0);
    xfer(16'h0077, 3'd5, 1'b0, 0);
    run_pkt(5, MAXW + 1, 0);
    run_pkt(0, MAXW, 0);

    bq.delete();
    put(32'h0099_0002, 1'b0, 0);
    put($urandom, 1'b0, 0);
    xfer(16'h0099, 3'd6, 1'b1, 10);

    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 6);
      n = (kind == 4) ? 0 : (kind == 5) ? int'($urandom_range(MAXW + 1, MAXW + 3)) : int'($urandom_range(1, 6));
      run_pkt(kind, n, $urandom_range(0, 3));
    end

    // Reset in the middle of a payload
    bq.delete();
    put(32'h0055_0004, 1'b0, 0);
    put($urandom, 1'b0, 0);
    put($urandom, 1'b0, 0);
    foreach (bq[i]) send_beat(bq[i].d, bq[i].l, bq[i].g);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    exp_ok  = 0;
    exp_bad = 0;
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_tag", 32'(res_tag), 0);
    chk("midrst_res_err", 32'(res_err), 0);
    chk("midrst_res_pass", 32'(res_pass), 0);
    chk("midrst_ok_cnt", 32'(pkt_ok_cnt), 0);
    chk("midrst_err_cnt", 32'(pkt_err_cnt), 0);
    @(negedge clk);
    chk("midrst_s_ready_back", 32'(s_ready), 1);
    run_pkt(0, 2, 0);

    // Drive the pass counter past its all-ones value
    for (int p = 0; p < MAXC + 4; p++) run_pkt(0, $urandom_range(1, 3), 0);
    chk("ok_cnt_saturated", 32'(pkt_ok_cnt), 32'(MAXC));
    run_pkt(1, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
